// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory slave for the MEM stage: accepts one load/store, waits WAIT_CYCLES, responds.
// Optional MISALIGN_TRAP_EN adds resp_err and blocks misaligned accesses.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        stall,
  output logic [1:0]  dbg_state
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        resp_err
`endif
);

  // Handshake: a request is accepted at a rising edge where req_valid=1 and
  // req_ready=1 (IDLE); resp_valid is a single-cycle completion pulse.
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [3:0]              r_cnt;
  logic                    r_write;
  logic                    r_mis;
  logic [31:0]             r_wdata;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [31:0]             r_rdata;
  logic [31:0]             r_mem [0:DEPTH-1];

  logic                    w_accept;
  logic                    w_enter_resp;
  logic [ADDR_WIDTH-1:0]   w_req_idx;
  logic                    w_req_mis;
  logic [ADDR_WIDTH-1:0]   w_rd_idx;
  logic                    w_rd_write;
  logic                    w_rd_mis;
  logic                    w_unused;

  assign w_req_idx = req_addr[ADDR_WIDTH+1:2];
  assign w_unused  = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};
`ifdef MISALIGN_TRAP_EN
  assign w_req_mis = (req_addr[1:0] != 2'b00);
`else
  assign w_req_mis = 1'b0;
`endif

  assign w_accept  = (r_state == S_IDLE) && req_valid && !reset;
  assign dbg_state = r_state;

  // With zero wait states RESP is entered straight from IDLE, before the
  // request has been captured, so the read uses the live request fields.
  assign w_rd_idx   = (r_state == S_IDLE) ? w_req_idx : r_idx;
  assign w_rd_write = (r_state == S_IDLE) ? req_write : r_write;
  assign w_rd_mis   = (r_state == S_IDLE) ? w_req_mis : r_mis;

  always_comb begin
    w_next_state = r_state;
    w_enter_resp = 1'b0;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    stall        = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_next_state = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (r_cnt == 4'd0) begin
          w_next_state = S_RESP;
          w_enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        resp_valid   = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    // A cycle spent in reset never signals completion or freezes the core.
    if (reset) begin
      req_ready    = 1'b1;
      resp_valid   = 1'b0;
      stall        = 1'b0;
      w_enter_resp = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_mis   <= 1'b0;
      r_wdata <= 32'd0;
      r_idx   <= '0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_write <= req_write;
        r_mis   <= w_req_mis;
        r_wdata <= req_wdata;
        r_idx   <= w_req_idx;
        r_cnt   <= WAIT_INIT;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        if (w_rd_mis)
          r_rdata <= 32'd0;
        else if (!w_rd_write)
          r_rdata <= r_mem[w_rd_idx];
      end
    end
  end

  // Store commits at the edge closing RESP; a reset in that cycle drops it.
  always_ff @(posedge clock) begin
    if (!reset && r_state == S_RESP && r_write && !r_mis)
      r_mem[r_idx] <= r_wdata;
  end

  assign resp_rdata = r_rdata;
`ifdef MISALIGN_TRAP_EN
  assign resp_err = (r_state == S_RESP) && r_mis && !reset;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: instance 0 with WAIT_CYCLES=2, instance 1 with WAIT_CYCLES=0.
// Honours MISALIGN_TRAP_EN when defined.
module tb_data_mem_responder;

  logic        clock;
  logic        reset;
  logic        req_valid  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        stall      [2];
  logic [1:0]  dbg_state  [2];
`ifdef MISALIGN_TRAP_EN
  logic        resp_err   [2];
`endif

  int n_checks = 0;
  int n_pass   = 0;

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_ready(req_ready[0]), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .stall(stall[0]), .dbg_state(dbg_state[0])
`ifdef MISALIGN_TRAP_EN
    , .resp_err(resp_err[0])
`endif
  );

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_ready(req_ready[1]), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .stall(stall[1]), .dbg_state(dbg_state[1])
`ifdef MISALIGN_TRAP_EN
    , .resp_err(resp_err[1])
`endif
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issues one request on instance sel for a single cycle, then records
  // stall/resp_valid over cycles T..T+7 and the data/err of the response.
  task automatic access(input int sel, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic [7:0] stall_h, output logic [7:0] rv_h,
                        output logic err);
    @(posedge clock); #1;
    req_valid[sel] = 1'b1;
    req_write[sel] = wr;
    req_addr[sel]  = addr;
    req_wdata[sel] = wdata;
    stall_h = '0; rv_h = '0; rdata = '0; err = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      stall_h[c] = stall[sel];
      rv_h[c]    = resp_valid[sel];
      if (resp_valid[sel]) begin
        rdata = resp_rdata[sel];
`ifdef MISALIGN_TRAP_EN
        err = resp_err[sel];
`endif
      end
      @(posedge clock); #1;
      req_valid[sel] = 1'b0;
    end
  endtask

  logic [31:0] rd, d0, d1;
  logic [7:0]  sh, rh;
  logic [4:0]  rdy5, rv5;
  logic        er;
  int          rv_cnt;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0;
    end

    // reset, request idle
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ready", {31'd0, req_ready[0]}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
    check("rst_rdata", resp_rdata[0], 32'd0);
    check("rst_stall", {31'd0, stall[0]}, 32'd0);
    check("rst_state", {30'd0, dbg_state[0]}, 32'd0);

    // reset with req_valid held
    @(posedge clock); #1;
    req_valid[0] = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rstv_ready", {31'd0, req_ready[0]}, 32'd1);
    check("rstv_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
    check("rstv_rdata", resp_rdata[0], 32'd0);
    check("rstv_stall", {31'd0, stall[0]}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    req_valid[0] = 1'b0;

    // store/load with two wait states
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, sh, rh, er);
    check("st_stall_hist", {24'd0, sh}, 32'h07);
    check("st_rv_hist", {24'd0, rh}, 32'h08);
    access(0, 1'b0, 32'h10, 32'h0, rd, sh, rh, er);
    check("ld_rv_hist", {24'd0, rh}, 32'h08);
    check("ld_rdata", rd, 32'hDEADBEEF);

    // address wrap: 0x400 maps to word 0
    access(0, 1'b1, 32'h400, 32'h12345678, rd, sh, rh, er);
    access(0, 1'b0, 32'h000, 32'h0, rd, sh, rh, er);
    check("wrap_rdata", rd, 32'h12345678);

    // reset in the middle of a store
    access(0, 1'b1, 32'h20, 32'h11111111, rd, sh, rh, er);
    @(posedge clock); #1;
    req_valid[0] = 1'b1; req_write[0] = 1'b1;
    req_addr[0] = 32'h20; req_wdata[0] = 32'hAAAAAAAA;
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    reset = 1'b1;
    rv_cnt = 0;
    @(negedge clock);
    rv_cnt += int'(resp_valid[0]);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      rv_cnt += int'(resp_valid[0]);
    end
    check("rstmid_no_resp", rv_cnt, 32'd0);
    check("rstmid_ready", {31'd0, req_ready[0]}, 32'd1);
    access(0, 1'b0, 32'h20, 32'h0, rd, sh, rh, er);
    check("rstmid_rdata", rd, 32'h11111111);

    // misaligned access to word 0x10 (holds 0xDEADBEEF)
`ifdef MISALIGN_TRAP_EN
    access(0, 1'b0, 32'h13, 32'h0, rd, sh, rh, er);
    check("mis_ld_err", {31'd0, er}, 32'd1);
    check("mis_ld_rdata", rd, 32'd0);
    check("mis_ld_rv_hist", {24'd0, rh}, 32'h08);
    access(0, 1'b1, 32'h13, 32'h55, rd, sh, rh, er);
    check("mis_st_err", {31'd0, er}, 32'd1);
    access(0, 1'b0, 32'h10, 32'h0, rd, sh, rh, er);
    check("mis_st_word", rd, 32'hDEADBEEF);
    check("aligned_err", {31'd0, er}, 32'd0);
`else
    access(0, 1'b0, 32'h13, 32'h0, rd, sh, rh, er);
    check("unal_ld_rdata", rd, 32'hDEADBEEF);
`endif

    // zero wait states: single access, then back-to-back with valid held
    access(1, 1'b1, 32'h40, 32'hA5A50001, rd, sh, rh, er);
    check("w0_stall_hist", {24'd0, sh}, 32'h01);
    check("w0_rv_hist", {24'd0, rh}, 32'h02);
    access(1, 1'b1, 32'h44, 32'h5A5A0002, rd, sh, rh, er);
    @(posedge clock); #1;
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h40;
    d0 = '0; d1 = '0; rdy5 = '0; rv5 = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      rv5[c]  = resp_valid[1];
      rdy5[c] = req_ready[1];
      if (c == 1) d0 = resp_rdata[1];
      if (c == 3) d1 = resp_rdata[1];
      @(posedge clock); #1;
      if (c == 0) req_addr[1] = 32'h44;
      if (c == 2) req_valid[1] = 1'b0;
    end
    check("b2b_rv_hist", {27'd0, rv5}, 32'h0A);
    check("b2b_ready_hist", {27'd0, rdy5}, 32'h15);
    check("b2b_rdata0", d0, 32'hA5A50001);
    check("b2b_rdata1", d1, 32'h5A5A0002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
